imm_gen_pipe: RTL and testbench

- Registered, handshaked RISC-V immediate generator for the decode stage; successor to the I-type-only extractor.
- Decodes all RV32I/RV64I immediate formats (R/I/S/B/U/J) from the opcode field and sign-extends to XLEN.
- Provides valid/ready flow control with full throughput and backpressure.
- Flags illegal opcodes and keeps a saturating illegal-instruction counter for debug.

---
 rtl/imm_gen_if.sv | 20 ++
 rtl/imm_gen_pipe.sv | 65 ++++++
 tb/tb_imm_gen_pipe.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready instruction-in, immediate-out bundle for imm_gen_pipe
interface imm_gen_if #(parameter int XLEN = 32, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_cnt
  );
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate decoder with valid/ready flow control
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input logic       clk,
  input logic       rst,
  imm_gen_if.slave  bus
);
  logic [31:0]      ins;
  logic             accept;
  logic [2:0]       fmt_d, fmt_q;
  logic [XLEN-1:0]  imm_d, imm_q;
  logic             ill_d, ill_q, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign ins          = bus.in_instr;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  always_comb begin
    fmt_d = 3'd7;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: fmt_d = 3'd1;
      7'b0100011: fmt_d = 3'd2;
      7'b1100011: fmt_d = 3'd3;
      7'b0110111, 7'b0010111: fmt_d = 3'd4;
      7'b1101111: fmt_d = 3'd5;
      7'b0110011: fmt_d = 3'd0;
      default: fmt_d = 3'd7;
    endcase
  end
  assign ill_d = fmt_d == 3'd7;
  // Signed size casts replicate instr[31] up to XLEN-1 for every format
  always_comb
    imm_d = fmt_d == 3'd1 ? XLEN'($signed(ins[31:20])) :
            fmt_d == 3'd2 ? XLEN'($signed({ins[31:25], ins[11:7]})) :
            fmt_d == 3'd3 ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
            fmt_d == 3'd4 ? XLEN'($signed({ins[31:12], 12'b0})) :
            fmt_d == 3'd5 ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
            '0;
  assign cnt_d = (accept && ill_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      fmt_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        imm_q   <= imm_d;
        fmt_q   <= fmt_d;
        ill_q   <= ill_d;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      cnt_q <= cnt_d;
    end
  end
  assign bus.out_valid   = valid_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_fmt     = fmt_q;
  assign bus.out_illegal = ill_q;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized and directed checks of imm_gen_pipe against an arithmetic reference model
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  imm_gen_if #(.XLEN(32), .CNT_W(8)) b32();
  imm_gen_if #(.XLEN(64), .CNT_W(8)) b64();
  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (.clk(clk), .rst(rst), .bus(b64));
  typedef struct packed {logic [63:0] imm; logic [2:0] fmt; logic ill;} res_t;
  int   checks = 0;
  int   errors = 0;
  logic e_valid;
  res_t e_res;
  int   e_cnt;
  // Immediate value built as a signed integer from weighted instruction fields
  function automatic res_t ref_dec(input logic [31:0] ins, input int xlen);
    res_t   r;
    longint v;
    r.fmt = 3'd7;
    v = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        r.fmt = 3'd1; v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
      end
      7'h23: begin
        r.fmt = 3'd2; v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
      end
      7'h63: begin
        r.fmt = 3'd3;
        v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32 + longint'(ins[7]) * 2048 - (ins[31] ? 4096 : 0);
      end
      7'h37, 7'h17: begin
        r.fmt = 3'd4; v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'h1_0000_0000 : 64'h0);
      end
      7'h6F: begin
        r.fmt = 3'd5;
        v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048 + longint'(ins[19:12]) * 4096 - (ins[31] ? (1 << 20) : 0);
      end
      7'h33: r.fmt = 3'd0;
      default: r.fmt = 3'd7;
    endcase
    r.ill = r.fmt == 3'd7;
    r.imm = xlen == 32 ? {32'h0, v[31:0]} : v;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
    logic [31:0] junk;
    junk = $urandom;
    b32.in_valid  = v;
    b32.in_instr  = v ? ins : junk;
    b32.out_ready = rdy;
    if (v && (!e_valid || rdy)) begin
      e_res   = ref_dec(ins, 32);
      e_valid = 1'b1;
      if (e_res.ill && e_cnt < 255) e_cnt++;
    end else if (rdy) begin
      e_valid = 1'b0;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.out_ready = 1'b1;
    e_valid = 1'b0; e_res = '0; e_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt, b32.in_ready} !== {1'b0, 32'h0, 3'd0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset32: got v=%b imm=%h fmt=%0d ill=%b cnt=%0d rdy=%b, want all zero and rdy=1", b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt, b32.in_ready);
    end
    checks++;
    if ({b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_illegal, b64.illegal_cnt} !== '0) begin
      errors++;
      $display("FAIL reset64: got v=%b imm=%h fmt=%0d ill=%b cnt=%0d, want all zero", b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_illegal, b64.illegal_cnt);
    end
  endtask
  task automatic test_addi();
    drive(1'b1, 32'hFFF00093, 1'b1);
    tick();
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL addi: got v=%b imm=%h fmt=%0d ill=%b, want v=1 imm=ffffffff fmt=1 ill=0", b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    checks++;
    if (b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_retire: got out_valid=%b, want 0", b32.out_valid);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'hFE112E23, 32'h123450B7, 32'h80000063, 32'h800000EF};
    logic [31:0] imm [4] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFF000, 32'hFFF00000};
    logic [2:0]  fmt [4] = '{3'd2, 3'd4, 3'd3, 3'd5};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], 1'b1);
      #1;
      checks++;
      if (b32.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got in_ready=%b, want 1", i, b32.in_ready);
      end
      tick();
      checks++;
      if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal} !== {1'b1, imm[i], fmt[i], 1'b0}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b imm=%h fmt=%0d ill=%b, want v=1 imm=%h fmt=%0d ill=0", i, b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, imm[i], fmt[i]);
      end
    end
    drive(1'b0, '0, 1'b1);
    tick();
  endtask
  task automatic test_backpressure();
    drive(1'b1, 32'hFE112E23, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h123450B7, 1'b0);
      #1;
      checks++;
      if (b32.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got in_ready=%b, want 0", i, b32.in_ready);
      end
      tick();
      checks++;
      if ({b32.out_valid, b32.out_imm, b32.out_fmt} !== {1'b1, 32'hFFFFFFFC, 3'd2}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b imm=%h fmt=%0d, want v=1 imm=fffffffc fmt=2", i, b32.out_valid, b32.out_imm, b32.out_fmt);
      end
    end
    drive(1'b1, 32'h123450B7, 1'b1);
    #1;
    checks++;
    if (b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got in_ready=%b, want 1", b32.in_ready);
    end
    tick();
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt} !== {1'b1, 32'h12345000, 3'd4}) begin
      errors++;
      $display("FAIL bp_nobubble: got v=%b imm=%h fmt=%0d, want v=1 imm=12345000 fmt=4", b32.out_valid, b32.out_imm, b32.out_fmt);
    end
    drive(1'b0, '0, 1'b1);
    tick();
  endtask
  task automatic test_illegal_stall();
    do_reset();
    drive(1'b1, 32'h0000007F, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hABCDE07F, 1'b0);
      tick();
      checks++;
      if (b32.illegal_cnt !== 8'd1) begin
        errors++;
        $display("FAIL stall_cnt[%0d]: got illegal_cnt=%0d, want 1", i, b32.illegal_cnt);
      end
    end
    drive(1'b1, 32'hABCDE07F, 1'b1);
    tick();
    checks++;
    if ({b32.illegal_cnt, b32.out_illegal, b32.out_fmt} !== {8'd2, 1'b1, 3'd7}) begin
      errors++;
      $display("FAIL stall_release: got cnt=%0d ill=%b fmt=%0d, want cnt=2 ill=1 fmt=7", b32.illegal_cnt, b32.out_illegal, b32.out_fmt);
    end
  endtask
  task automatic test_illegal_saturate();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      drive(1'b1, {r[31:7], 7'h7F}, 1'b1);
      tick();
      checks++;
      if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt} !== {1'b1, 32'h0, 3'd7, 1'b1, 8'((i + 1 > 255) ? 255 : i + 1)}) begin
        errors++;
        $display("FAIL sat[%0d]: got v=%b imm=%h fmt=%0d ill=%b cnt=%0d, want v=1 imm=0 fmt=7 ill=1 cnt=%0d", i, b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt, (i + 1 > 255) ? 255 : i + 1);
      end
    end
  endtask
  task automatic test_random();
    logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    logic [31:0] r;
    logic [6:0]  op;
    logic        v, rdy, exp_rdy;
    int          k;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = $urandom;
      k   = $urandom_range(0, 12);
      op  = k == 12 ? r[6:0] : ops[k];
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
      exp_rdy = !e_valid || rdy;
      drive(v, {r[31:7], op}, rdy);
      #1;
      checks++;
      if (b32.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got in_ready=%b, want %b", i, b32.in_ready, exp_rdy);
      end
      tick();
      checks++;
      if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt} !== {e_valid, e_res.imm[31:0], e_res.fmt, e_res.ill, 8'(e_cnt)}) begin
        errors++;
        $display("FAIL rnd[%0d]: got v=%b imm=%h fmt=%0d ill=%b cnt=%0d, want v=%b imm=%h fmt=%0d ill=%b cnt=%0d", i, b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt, e_valid, e_res.imm[31:0], e_res.fmt, e_res.ill, e_cnt);
      end
    end
    drive(1'b0, '0, 1'b1);
    tick();
  endtask
  task automatic test_xlen64();
    logic [31:0] ins [2] = '{32'h800000B7, 32'h00000033};
    logic [63:0] imm [2] = '{64'hFFFFFFFF80000000, 64'h0};
    logic [2:0]  fmt [2] = '{3'd4, 3'd0};
    logic [6:0]  ops [6] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h17};
    logic [31:0] r;
    res_t        e;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b64.in_valid = 1'b1;
      b64.in_instr = ins[i];
      tick();
      checks++;
      if ({b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_illegal} !== {1'b1, imm[i], fmt[i], 1'b0}) begin
        errors++;
        $display("FAIL x64[%0d]: got v=%b imm=%h fmt=%0d ill=%b, want v=1 imm=%h fmt=%0d ill=0", i, b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_illegal, imm[i], fmt[i]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      b64.in_instr = {r[31:7], ops[i % 6]};
      e = ref_dec(b64.in_instr, 64);
      tick();
      checks++;
      if ({b64.out_imm, b64.out_fmt, b64.out_illegal} !== {e.imm, e.fmt, e.ill}) begin
        errors++;
        $display("FAIL x64rnd[%0d]: instr=%h got imm=%h fmt=%0d ill=%b, want imm=%h fmt=%0d ill=%b", i, {r[31:7], ops[i % 6]}, b64.out_imm, b64.out_fmt, b64.out_illegal, e.imm, e.fmt, e.ill);
      end
    end
    b64.in_valid = 1'b0;
    tick();
  endtask
  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 32'h0000007F, 1'b1);
    tick();
    drive(1'b1, 32'h00000013, 1'b0);
    tick();
    checks++;
    if ({b32.out_valid, b32.illegal_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL arst_pre: got v=%b cnt=%0d, want v=1 cnt=1", b32.out_valid, b32.illegal_cnt);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt} !== '0) begin
      errors++;
      $display("FAIL arst_now: got v=%b imm=%h fmt=%0d ill=%b cnt=%0d, want all zero", b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.illegal_cnt);
    end
    e_valid = 1'b0; e_res = '0; e_cnt = 0;
    #1 rst = 1'b0;
    drive(1'b1, 32'hFFF00093, 1'b1);
    tick();
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.illegal_cnt} !== {1'b1, 32'hFFFFFFFF, 3'd1, 8'd0}) begin
      errors++;
      $display("FAIL arst_after: got v=%b imm=%h fmt=%0d cnt=%0d, want v=1 imm=ffffffff fmt=1 cnt=0", b32.out_valid, b32.out_imm, b32.out_fmt, b32.illegal_cnt);
    end
    drive(1'b0, '0, 1'b1);
    tick();
  endtask
  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal_stall();
    test_illegal_saturate();
    test_random();
    test_xlen64();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
